// File: rtl/demux_pkg.sv
// ============================================================================
// Module  : demux_pkg
// Brief   : Shared constants and the lane-slice helper for the 1-to-8 demux.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package demux_pkg;

    localparam int LANES = 8;
    localparam int SEL_W = 3;
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

    // Bit offset of lane k inside the packed lane bus.
    function automatic int lane_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/demux1_8_if.sv
// ============================================================================
// Module  : demux1_8_if
// Brief   : Input beat handshake plus per-lane output handshakes of demux1_8.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface demux1_8_if #(
    parameter int WIDTH = 4
);
    logic                                    auto_mode;
    logic                                    in_valid;
    logic                                    in_ready;
    logic [WIDTH-1:0]                        in_data;
    logic [demux_pkg::SEL_W-1:0]             in_sel;
    logic [demux_pkg::LANES-1:0]             out_valid;
    logic [demux_pkg::LANES-1:0]             out_ready;
    logic [demux_pkg::LANES*WIDTH-1:0]       out_data;
    logic [demux_pkg::SEL_W-1:0]             ptr;
    logic                                    frame_done;

    modport master (
        output auto_mode, in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, ptr, frame_done
    );

    modport slave (
        input  auto_mode, in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, ptr, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/demux_lane.sv
// ============================================================================
// Module  : demux_lane
// Brief   : One-entry lane holding register with valid/ready output handshake.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_lane #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_data,
    input  wire logic             i_out_ready,
    output logic                  o_out_valid,
    output logic [WIDTH-1:0]      o_out_data,
    output logic                  o_free
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // A load wins over a drain so a same-cycle drain+load keeps the lane full.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;
    assign o_free      = !r_valid || i_out_ready;

endmodule

`default_nettype wire

// File: rtl/demux1_8.sv
// ============================================================================
// Module  : demux1_8
// Brief   : Registered 1-to-8 lane distributor with manual or round-robin select.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module demux1_8
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    demux1_8_if.slave   bus
);

    logic [SEL_W-1:0]       w_tgt;
    logic                   w_ready;
    logic                   w_accept;
    logic [LANES-1:0]       w_free;
    logic [LANES-1:0]       w_load;
    logic [LANES-1:0]       w_valid;
    logic [WIDTH-1:0]       w_lane_data [LANES];
    logic [LANES*WIDTH-1:0] w_out_data;
    logic [SEL_W-1:0]       r_ptr;
    logic                   r_frame_done;

    assign w_tgt    = bus.auto_mode ? r_ptr : bus.in_sel;
    assign w_ready  = w_free[w_tgt];
    assign w_accept = bus.in_valid && w_ready;

    always_comb begin
        w_load = '0;
        if (w_accept) begin
            w_load[w_tgt] = 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            demux_lane #(
                .WIDTH (WIDTH)
            ) u_lane (
                .clk         (clk),
                .rst         (rst),
                .i_load      (w_load[k]),
                .i_data      (bus.in_data),
                .i_out_ready (bus.out_ready[k]),
                .o_out_valid (w_valid[k]),
                .o_out_data  (w_lane_data[k]),
                .o_free      (w_free[k])
            );
        end
    endgenerate

    always_comb begin
        w_out_data = '0;
        for (int k = 0; k < LANES; k++) begin
            w_out_data[lane_lsb(k, WIDTH) +: WIDTH] = w_lane_data[k];
        end
    end

    // Pointer only moves on auto-mode accepts; the frame pulse marks the lane-7 wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && bus.auto_mode && (r_ptr == LAST_LANE);
            if (w_accept && bus.auto_mode) begin
                r_ptr <= r_ptr + 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.out_valid  = w_valid;
    assign bus.out_data   = w_out_data;
    assign bus.ptr        = r_ptr;
    assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_demux1_8.sv
// ============================================================================
// Module  : tb_demux1_8
// Brief   : Directed scoreboard bench for demux1_8 (per-lane expected queues).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_demux1_8;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [2:0] m_ptr = 3'd0;
    logic [3:0] exp_q [8][$];

    demux1_8_if #(.WIDTH(4)) bus ();

    demux1_8 #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat, wait (bounded) for acceptance, then record the expectation.
    task automatic send(input logic [2:0] sel, input logic [3:0] d);
        logic [2:0] tgt;
        int n;
        tgt = bus.auto_mode ? m_ptr : sel;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = sel;
        #1;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            check("send_ready", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q[tgt].push_back(d);
        if (bus.auto_mode) m_ptr = m_ptr + 3'd1;
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic clear_model();
        for (int k = 0; k < 8; k++) exp_q[k].delete();
        m_ptr = 3'd0;
    endtask

    // Monitor: every lane transfer (valid && ready) pops that lane's expected beat.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 8; k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_drain lane%0d: got %0h want none", k, bus.out_data[k*4 +: 4]);
                    end else begin
                        check($sformatf("drain_lane%0d", k), 32'(bus.out_data[k*4 +: 4]), 32'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.auto_mode = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'h0;
        bus.in_sel    = 3'd0;
        bus.out_ready = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_ptr", 32'(bus.ptr), 32'h0);
        check("rst_frame_done", 32'(bus.frame_done), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Manual single beat to lane 3.
        bus.out_ready = 8'hFF;
        send(3'd3, 4'hA);
        check("t1_out_valid", 32'(bus.out_valid), 32'h08);
        check("t1_out_data", bus.out_data, 32'h0000_A000);
        tick();
        check("t1_drained_valid", 32'(bus.out_valid), 32'h00);
        check("t1_data_held", bus.out_data, 32'h0000_A000);

        // Auto mode: a full frame of 8 beats with consumers stalled.
        bus.out_ready = 8'h00;
        bus.auto_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(3'd0, 4'(i));
            check($sformatf("t2_frame_done_%0d", i), 32'(bus.frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("t2_out_valid", 32'(bus.out_valid), 32'hFF);
        check("t2_out_data", bus.out_data, 32'h7654_3210);
        check("t2_ptr_wrap", 32'(bus.ptr), 32'h0);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h8;
        #1;
        check("t2_ninth_stalled", 32'(bus.in_ready), 32'h0);
        tick();
        bus.in_valid = 1'b0;
        check("t2_frame_done_once", 32'(bus.frame_done), 32'h0);
        check("t2_ptr_hold", 32'(bus.ptr), 32'h0);
        bus.out_ready = 8'hFF;
        tick();
        check("t2_all_drained", 32'(bus.out_valid), 32'h00);

        // Lane 5 stall in manual mode, lifted by retargeting to lane 2.
        bus.auto_mode = 1'b0;
        bus.out_ready = 8'hDF;
        send(3'd5, 4'h5);
        bus.in_valid = 1'b1;
        bus.in_data  = 4'h9;
        bus.in_sel   = 3'd5;
        #1;
        check("t3_stall_lane5", 32'(bus.in_ready), 32'h0);
        bus.in_sel = 3'd2;
        #1;
        check("t3_retarget_ready", 32'(bus.in_ready), 32'h1);
        @(posedge clk);
        exp_q[2].push_back(4'h9);
        #1;
        bus.in_valid = 1'b0;
        check("t3_out_valid", 32'(bus.out_valid), 32'h24);
        check("t3_lane2", 32'(bus.out_data[11:8]), 32'h9);
        bus.out_ready = 8'hFF;
        tick();
        tick();

        // Same-cycle drain and reload of lane 1.
        bus.out_ready = 8'h00;
        send(3'd1, 4'h3);
        bus.out_ready = 8'hFF;
        send(3'd1, 4'hC);
        check("t4_valid_kept", 32'(bus.out_valid), 32'h02);
        check("t4_lane1", 32'(bus.out_data[7:4]), 32'hC);
        tick();

        // Reset in the middle of an auto frame.
        bus.out_ready = 8'h00;
        bus.auto_mode = 1'b1;
        for (int i = 0; i < 4; i++) send(3'd0, 4'(i + 1));
        check("t5_ptr_before", 32'(bus.ptr), 32'h4);
        check("t5_valid_before", 32'(bus.out_valid), 32'h0F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_model();
        #1;
        check("t5_rst_valid", 32'(bus.out_valid), 32'h0);
        check("t5_rst_data", bus.out_data, 32'h0);
        check("t5_rst_ptr", 32'(bus.ptr), 32'h0);
        check("t5_rst_frame_done", 32'(bus.frame_done), 32'h0);
        send(3'd5, 4'hE);
        check("t5_lane0_valid", 32'(bus.out_valid), 32'h01);
        check("t5_lane0_data", bus.out_data, 32'h0000_000E);
        bus.out_ready = 8'hFF;
        tick();

        // Manual beats do not move the pointer; auto resumes at lane 6.
        for (int i = 0; i < 5; i++) send(3'd0, 4'(i + 1));
        check("t6_ptr6", 32'(bus.ptr), 32'h6);
        bus.auto_mode = 1'b0;
        send(3'd0, 4'hB);
        send(3'd7, 4'hD);
        check("t6_ptr_manual_hold", 32'(bus.ptr), 32'h6);
        bus.auto_mode = 1'b1;
        send(3'd0, 4'h6);
        check("t6_lane6_valid", 32'(bus.out_valid), 32'h40);
        check("t6_fd_after6", 32'(bus.frame_done), 32'h0);
        send(3'd0, 4'h7);
        check("t6_lane7_valid", 32'(bus.out_valid), 32'h80);
        check("t6_fd_after7", 32'(bus.frame_done), 32'h1);
        check("t6_ptr_wrap", 32'(bus.ptr), 32'h0);
        tick();
        check("t6_fd_cleared", 32'(bus.frame_done), 32'h0);

        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("end_queue_empty_lane%0d", k), 32'(exp_q[k].size()), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux1_8.md
# demux1_8

Registered 1-to-8 lane distributor: the inverse of the 8:1 nibble lane mux. It accepts one WIDTH-bit beat per cycle on a valid/ready input and steers it into one of eight output lanes. Each lane has a one-entry holding register with its own valid/ready handshake. The target lane comes from an external select or, in auto mode, from an internal round-robin pointer, which makes the block a serial-to-parallel lane spreader feeding the mux-based datapath.

## Interface
- WIDTH, 4, bits per beat and per lane.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- auto_mode  input  1  1 = lane from internal pointer; 0 = lane from in_sel.
- in_valid  input  1  input beat present.
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
- in_data  input  WIDTH  beat payload.
- in_sel  input  3  target lane in manual mode; ignored in auto mode.
- out_valid  output  8  per-lane holding register full.
- out_ready  input  8  per-lane consumer ready.
- out_data  output  8*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
- ptr  output  3  current round-robin pointer.
- frame_done  output  1  one-cycle pulse after the lane-7 beat is accepted in auto mode.

## Operation
- Target lane: tgt = auto_mode ? ptr : in_sel.
- in_ready = !out_valid[tgt] || out_ready[tgt]. This is combinational from the handshake inputs, auto_mode, in_sel and the lane state. It must not depend on in_valid.
- Accept (in_valid && in_ready):
  - lane tgt loads in_data;
  - out_valid[tgt] is 1 next cycle.
- Drain of lane k (out_valid[k] && out_ready[k]) with no load to k: out_valid[k] is 0 next cycle. out_data[k] holds its last value.
- Simultaneous drain and load on the same lane: the new data replaces the old and out_valid stays 1. No bubble, no loss.
- Other lanes are unaffected by an accept; any number of lanes may drain in the same cycle.
- Pointer behaviour:
  - ptr advances by 1 only on an accept while auto_mode = 1, wrapping 7 -> 0.
  - In manual mode ptr holds its value.
  - Toggling auto_mode does not reset ptr.
- frame_done is registered. It is 1 for exactly the cycle after an auto-mode accept at ptr = 7, and 0 otherwise.
- Reset, including mid-transfer:
  - out_valid = 0, out_data = 0, ptr = 0, frame_done = 0;
  - any pending lane contents are discarded;
  - in_ready is evaluated from the reset lane state.

## Timing
- Latency: a beat accepted at edge N is visible on out_data/out_valid of its lane after edge N, i.e. 1 cycle.
- Throughput: 1 beat per cycle while the target lane is empty or draining.
- A full lane with out_ready low stalls the input: in_ready = 0. In manual mode the stall applies only while that lane is selected. Retargeting in_sel to a free lane lifts it the same cycle.
- in_data, in_sel and auto_mode are sampled only on an accepted edge.
- After a stall, the sender must hold in_valid until accepted; the block does not require in_data to stay stable.

## Structure
- Package demux_pkg: LANES = 8, SEL_W = 3, and the lane-slice helper (k*WIDTH offset).
- Sub-module demux_lane (parameter WIDTH):
  - one-entry holding register with load, data_in, out_valid, out_ready, out_data and a free output = !out_valid || out_ready;
  - instantiated 8 times.
- Top level contains:
  - the tgt select;
  - in_ready, taken from the free output of lane tgt;
  - the one-hot load decode;
  - the pointer and frame_done registers.

## Test plan
- Reset then manual mode, all out_ready = 1; send in_sel = 3, data 0xA. Required: out_valid = 8'b0000_1000 and lane 3 = 0xA one cycle later; the other lanes read 0.
- Auto mode, 8 back-to-back beats 0x0..0x7 with out_ready = 0:
  - lanes 0..7 hold 0..7 and out_valid = 0xFF;
  - frame_done pulses once, the cycle after the 0x7 beat;
  - ptr returns to 0;
  - a 9th beat sees in_ready = 0.
- Lane 5 full, out_ready[5] = 0, manual in_sel = 5: in_ready = 0. Switch in_sel to 2: in_ready = 1 the same cycle and lane 2 loads.
- Lane 1 full with 0x3, out_ready[1] = 1, and a simultaneous accept of 0xC to lane 1: next cycle lane 1 = 0xC and out_valid[1] stays 1.
- Auto mode, ptr at 4 with lanes 0..3 loaded; assert rst for one cycle: all outputs, including ptr and frame_done, return to 0. The next auto beat lands in lane 0.
- Manual beats while ptr = 6: ptr stays 6. Return to auto mode: the next beat lands in lane 6, then lane 7, then frame_done pulses.
